nv_nvdla_cdp_rdma_req_sched: RTL and testbench
==============================================

// Module: nv_nvdla_cdp_rdma_req_sched
// PURPOSE
//  Read-request scheduler between CDP RDMA ingress and the two DMA read ports (MCIF/CVIF).
//  Admits each ingress request only if the egress latency FIFO has room for its return atoms.
//  Routes admitted requests to MCIF or CVIF by src_ram_type through a 1-entry output register.
//  Counts read-stall cycles for the perf register.
// PARAMETERS
//  REQ_PD_W   79   request payload width: [63:0] addr, [78:64] size (atoms-1)
//  CDT_DEPTH  256  latency-FIFO entries (atoms) shared by both ports; power of 2 not required
//  CDT_W      9    credit counter width, must hold 0..CDT_DEPTH
// PORTS
//  nvdla_core_clk         in   1         single clock
//  nvdla_core_rst         in   1         synchronous, active-high reset
//  op_load                in   1         1-cycle layer-start pulse
//  reg2dp_src_ram_type    in   1         1=MCIF, 0=CVIF; sampled per accepted request
//  ig_req_valid           in   1         ingress request valid
//  ig_req_ready           out  1         ingress request ready
//  ig_req_pd              in   REQ_PD_W  ingress request payload
//  cdp2mcif_rd_req_valid  out  1         MCIF request valid
//  cdp2mcif_rd_req_ready  in   1         MCIF ready
//  cdp2mcif_rd_req_pd     out  REQ_PD_W  MCIF payload
//  cdp2cvif_rd_req_valid  out  1         CVIF request valid
//  cdp2cvif_rd_req_ready  in   1         CVIF ready
//  cdp2cvif_rd_req_pd     out  REQ_PD_W  CVIF payload
//  mcif_cdt_pop           in   1         egress freed one latency-FIFO entry (MCIF data)
//  cvif_cdt_pop           in   1         egress freed one latency-FIFO entry (CVIF data)
//  dma_busy               out  1         requests or credits outstanding
//  cdt_err                out  1         sticky: credit overflow or oversize request
//  dp2reg_perf_read_stall out  32        stall-cycle counter
// BEHAVIOUR
//  Reset: both *_rd_req_valid=0, ig_req_ready=0, cdt_avail=CDT_DEPTH, perf=0, cdt_err=0, dma_busy=0.
//  need = ig_req_pd[78:64]+1, computed at 16 bits (no wrap at size=0x7FFF).
//  out_free = !out_vld | (selected port ready).
//  ig_req_ready = out_free & (cdt_avail >= need), combinational; cdt_avail is the registered value only.
//  Accept (valid&ready): load out_pd, out_vld=1, out_sel=ram_type; next cycle the port sees valid.
//  The ingress-to-port latency is 1 cycle. Back-to-back accepts sustain 1 req/cycle while ports are ready.
//  Port outputs: mcif_valid=out_vld&out_sel, cvif_valid=out_vld&!out_sel; pd drives both ports.
//  Valid holds and pd is stable until the selected port is ready. out_sel is never changed mid-request.
//  Credits: cdt_next = cdt_avail - (accept?need:0) + mcif_cdt_pop + cvif_cdt_pop (both pops in a cycle = +2).
//  Overflow: if cdt_next > CDT_DEPTH, clamp to CDT_DEPTH and set cdt_err.
//  Oversize: a valid request with need > CDT_DEPTH is never accepted. It sets cdt_err (software-illegal).
//  ram_type change: affects only subsequently accepted requests; queued out_sel is unaffected.
//  Stall counter: +1 each cycle ig_req_valid & !ig_req_ready. Saturates at 0xFFFFFFFF.
//  op_load: clears perf and cdt_err. It does not touch credits or out_vld.
//  If op_load coincides with a stall cycle, perf becomes 0 (clear wins).
//  dma_busy = out_vld | (cdt_avail != CDT_DEPTH), registered.
//  Reset mid-operation: all state returns to reset values. In-flight credits are dropped.
//  Egress is reset by the same rst.
// TESTING
//  1. Reset, ram_type=1, req size=3, mcif ready -> mcif_valid 1 cycle later with pd intact.
//     Then cdt_avail=252 and dma_busy=1.
//  2. 64 reqs of size=3 with no pops -> ig_req_ready=0 on the 65th. perf increments each waiting cycle.
//     Then 4 mcif pops -> that request is accepted the following cycle.
//  3. mcif_ready=0 with a request held for 5 cycles -> valid/pd stable and the 2nd request not accepted.
//     ready=1 -> 1 req/cycle thereafter.
//  4. Accept (need=4) with both pops in the same cycle from cdt=100 -> cdt_avail=98.
//  5. Pop with cdt_avail=CDT_DEPTH -> stays CDT_DEPTH and cdt_err=1. op_load -> cdt_err=0, perf=0.
//  6. Alternate ram_type 1/0 per request -> requests alternate mcif/cvif in order. None dropped or duplicated.

Source files
------------

// File: rtl/nv_nvdla_cdp_rdma_req_sched.sv
// CDP RDMA read-request scheduler: credit-gated admission into a 1-entry output
// register that steers each request to MCIF or CVIF, plus read-stall perf counter.
module nv_nvdla_cdp_rdma_req_sched #(
   parameter int REQ_PD_W  = 79,
   parameter int CDT_DEPTH = 256,
   parameter int CDT_W     = 9
) (
   input  logic                nvdla_core_clk,
   input  logic                nvdla_core_rst,
   input  logic                op_load,
   input  logic                reg2dp_src_ram_type,
   input  logic                ig_req_valid,
   output logic                ig_req_ready,
   input  logic [REQ_PD_W-1:0] ig_req_pd,
   output logic                cdp2mcif_rd_req_valid,
   input  logic                cdp2mcif_rd_req_ready,
   output logic [REQ_PD_W-1:0] cdp2mcif_rd_req_pd,
   output logic                cdp2cvif_rd_req_valid,
   input  logic                cdp2cvif_rd_req_ready,
   output logic [REQ_PD_W-1:0] cdp2cvif_rd_req_pd,
   input  logic                mcif_cdt_pop,
   input  logic                cvif_cdt_pop,
   output logic                dma_busy,
   output logic                cdt_err,
   output logic [31:0]         dp2reg_perf_read_stall
);

   logic [REQ_PD_W-1:0] out_pd_q, out_pd_d;
   logic                out_vld_q, out_vld_d;
   logic                out_sel_q, out_sel_d;
   logic [CDT_W-1:0]    cdt_avail_q, cdt_avail_d;
   logic [31:0]         perf_q, perf_d;
   logic                cdt_err_q, cdt_err_d;
   logic                dma_busy_q, dma_busy_d;

   logic [15:0] need;
   logic [31:0] cdt_sum;
   logic        out_free, accept, cdt_ovf, oversize, stall;

   always_comb begin
      // 16-bit so size=0x7FFF yields 0x8000 rather than wrapping to 0
      need     = {1'b0, ig_req_pd[78:64]} + 16'd1;
      out_free = !out_vld_q | (out_sel_q ? cdp2mcif_rd_req_ready : cdp2cvif_rd_req_ready);
      ig_req_ready = !nvdla_core_rst & out_free & (32'(cdt_avail_q) >= 32'(need));
      accept   = ig_req_valid & ig_req_ready;

      out_vld_d = out_vld_q;
      out_sel_d = out_sel_q;
      out_pd_d  = out_pd_q;
      if (accept) begin
         out_vld_d = 1'b1;
         out_sel_d = reg2dp_src_ram_type;
         out_pd_d  = ig_req_pd;
      end else if (out_free) begin
         out_vld_d = 1'b0;
      end

      cdt_sum = 32'(cdt_avail_q) - (accept ? 32'(need) : 32'd0)
              + 32'(mcif_cdt_pop) + 32'(cvif_cdt_pop);
      cdt_ovf = cdt_sum > 32'(CDT_DEPTH);
      cdt_avail_d = cdt_ovf ? CDT_W'(CDT_DEPTH) : cdt_sum[CDT_W-1:0];

      oversize  = ig_req_valid & (32'(need) > 32'(CDT_DEPTH));
      cdt_err_d = op_load ? 1'b0 : (cdt_err_q | cdt_ovf | oversize);

      stall  = ig_req_valid & !ig_req_ready;
      perf_d = perf_q;
      if (op_load)
         perf_d = 32'd0;
      else if (stall && (perf_q != 32'hFFFF_FFFF))
         perf_d = perf_q + 32'd1;

      dma_busy_d = out_vld_d | (cdt_avail_d != CDT_W'(CDT_DEPTH));
   end

   always_ff @(posedge nvdla_core_clk) begin
      if (nvdla_core_rst) begin
         out_pd_q    <= '0;
         out_vld_q   <= 1'b0;
         out_sel_q   <= 1'b0;
         cdt_avail_q <= CDT_W'(CDT_DEPTH);
         perf_q      <= 32'd0;
         cdt_err_q   <= 1'b0;
         dma_busy_q  <= 1'b0;
      end else begin
         out_pd_q    <= out_pd_d;
         out_vld_q   <= out_vld_d;
         out_sel_q   <= out_sel_d;
         cdt_avail_q <= cdt_avail_d;
         perf_q      <= perf_d;
         cdt_err_q   <= cdt_err_d;
         dma_busy_q  <= dma_busy_d;
      end
   end

   assign cdp2mcif_rd_req_valid  = out_vld_q & out_sel_q;
   assign cdp2cvif_rd_req_valid  = out_vld_q & !out_sel_q;
   assign cdp2mcif_rd_req_pd     = out_pd_q;
   assign cdp2cvif_rd_req_pd     = out_pd_q;
   assign dma_busy               = dma_busy_q;
   assign cdt_err                = cdt_err_q;
   assign dp2reg_perf_read_stall = perf_q;

endmodule

// File: tb/tb_nv_nvdla_cdp_rdma_req_sched.sv
// Directed bench: a vector table for single-cycle behaviour plus hand sequences
// for credit exhaustion, backpressure, simultaneous pops, overflow and routing.
module tb_nv_nvdla_cdp_rdma_req_sched;

   logic        clk = 1'b0;
   logic        rst, op_load, ram_type, ig_valid, ig_ready;
   logic [78:0] ig_pd;
   logic        mv, mr, cv, cr, mp, cp, busy, err;
   logic [78:0] mpd, cpd;
   logic [31:0] perf;

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   nv_nvdla_cdp_rdma_req_sched dut (
      .nvdla_core_clk(clk), .nvdla_core_rst(rst), .op_load(op_load),
      .reg2dp_src_ram_type(ram_type),
      .ig_req_valid(ig_valid), .ig_req_ready(ig_ready), .ig_req_pd(ig_pd),
      .cdp2mcif_rd_req_valid(mv), .cdp2mcif_rd_req_ready(mr), .cdp2mcif_rd_req_pd(mpd),
      .cdp2cvif_rd_req_valid(cv), .cdp2cvif_rd_req_ready(cr), .cdp2cvif_rd_req_pd(cpd),
      .mcif_cdt_pop(mp), .cvif_cdt_pop(cp),
      .dma_busy(busy), .cdt_err(err), .dp2reg_perf_read_stall(perf)
   );

   typedef struct {
      logic rst, opl, rt, v; logic [14:0] sz; logic mr, cr, mp, cp;
      logic rdy, mv, cv, busy, err; logic [31:0] perf; logic [31:0] cdt;
   } vec_t;

   function automatic vec_t mk(input logic r, opl, rt, v, input logic [14:0] sz,
                               input logic mr_i, cr_i, mp_i, cp_i,
                               input logic rdy, mv_e, cv_e, busy_e, err_e,
                               input int perf_e, input int cdt_e);
      vec_t t;
      t.rst = r; t.opl = opl; t.rt = rt; t.v = v; t.sz = sz;
      t.mr = mr_i; t.cr = cr_i; t.mp = mp_i; t.cp = cp_i;
      t.rdy = rdy; t.mv = mv_e; t.cv = cv_e; t.busy = busy_e; t.err = err_e;
      t.perf = 32'(perf_e); t.cdt = 32'(cdt_e);
      return t;
   endfunction

   task automatic chk1(input string nm, input logic act, input logic exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0b expected %0b", nm, act, exp);
      end
   endtask

   task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic chkpd(input string nm, input logic [78:0] exp);
      n_chk++;
      if (mpd !== exp || cpd !== exp) begin
         n_fail++;
         $display("FAIL %s: got mcif %0h cvif %0h expected %0h", nm, mpd, cpd, exp);
      end
   endtask

   task automatic drive(input logic r, opl, rt, v, input logic [14:0] sz,
                        input logic [63:0] addr, input logic mr_i, cr_i, mp_i, cp_i);
      @(negedge clk);
      rst = r; op_load = opl; ram_type = rt; ig_valid = v; ig_pd = {sz, addr};
      mr = mr_i; cr = cr_i; mp = mp_i; cp = cp_i;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      drive(1'b1, 1'b0, 1'b0, 1'b0, 15'd0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
   endtask

   vec_t        tbl[11];
   logic [78:0] exp_pd;

   initial begin
      rst = 1'b1; op_load = 1'b0; ram_type = 1'b0; ig_valid = 1'b0; ig_pd = '0;
      mr = 1'b0; cr = 1'b0; mp = 1'b0; cp = 1'b0;
      exp_pd = '0;

      //            rst opl rt v  sz        mr cr mp cp  rdy mv cv bsy err perf cdt
      tbl[0]  = mk(1, 0, 0, 1'b0, 15'd3,    1, 1, 0, 0,  0, 0, 0, 0, 0, 0, 256);
      tbl[1]  = mk(0, 0, 1, 1'b0, 15'd3,    1, 1, 0, 0,  1, 0, 0, 0, 0, 0, 256);
      tbl[2]  = mk(0, 0, 1, 1'b1, 15'd3,    1, 0, 0, 0,  1, 1, 0, 1, 0, 0, 252);
      tbl[3]  = mk(0, 0, 1, 1'b0, 15'd3,    1, 0, 0, 0,  1, 0, 0, 1, 0, 0, 252);
      tbl[4]  = mk(0, 0, 0, 1'b1, 15'd7,    1, 0, 0, 0,  1, 0, 1, 1, 0, 0, 244);
      tbl[5]  = mk(0, 0, 1, 1'b1, 15'd0,    1, 0, 0, 0,  0, 0, 1, 1, 0, 1, 244);
      tbl[6]  = mk(0, 0, 1, 1'b1, 15'd0,    0, 1, 0, 0,  1, 1, 0, 1, 0, 1, 243);
      tbl[7]  = mk(0, 0, 1, 1'b0, 15'd0,    1, 0, 1, 1,  1, 0, 0, 1, 0, 1, 245);
      tbl[8]  = mk(0, 0, 1, 1'b1, 15'h7FFF, 1, 0, 0, 0,  0, 0, 0, 1, 1, 2, 245);
      tbl[9]  = mk(0, 1, 1, 1'b0, 15'd3,    1, 0, 0, 0,  1, 0, 0, 1, 0, 0, 245);
      tbl[10] = mk(1, 0, 1, 1'b1, 15'd3,    1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 256);

      for (int i = 0; i < 11; i++) begin
         drive(tbl[i].rst, tbl[i].opl, tbl[i].rt, tbl[i].v, tbl[i].sz,
               64'hA000_0000 + 64'(i), tbl[i].mr, tbl[i].cr, tbl[i].mp, tbl[i].cp);
         chk1($sformatf("tbl%0d_rdy", i), ig_ready, tbl[i].rdy);
         if (tbl[i].v && tbl[i].rdy) exp_pd = ig_pd;
         tick();
         chk1($sformatf("tbl%0d_mv", i), mv, tbl[i].mv);
         chk1($sformatf("tbl%0d_cv", i), cv, tbl[i].cv);
         chk1($sformatf("tbl%0d_busy", i), busy, tbl[i].busy);
         chk1($sformatf("tbl%0d_err", i), err, tbl[i].err);
         chk32($sformatf("tbl%0d_perf", i), perf, tbl[i].perf);
         chk32($sformatf("tbl%0d_cdt", i), 32'(dut.cdt_avail_q), tbl[i].cdt);
         if (tbl[i].mv || tbl[i].cv) chkpd($sformatf("tbl%0d_pd", i), exp_pd);
      end

      // Credit exhaustion: 64 x 4 atoms drains all 256, then 4 pops admit the 65th
      do_reset();
      for (int k = 0; k < 64; k++) begin
         drive(1'b0, 1'b0, 1'b1, 1'b1, 15'd3, 64'h100 + 64'(k), 1'b1, 1'b0, 1'b0, 1'b0);
         chk1($sformatf("fill%0d_rdy", k), ig_ready, 1'b1);
         tick();
         chk1($sformatf("fill%0d_mv", k), mv, 1'b1);
         chkpd($sformatf("fill%0d_pd", k), {15'd3, 64'h100 + 64'(k)});
      end
      chk32("fill_cdt0", 32'(dut.cdt_avail_q), 32'd0);
      for (int k = 0; k < 3; k++) begin
         drive(1'b0, 1'b0, 1'b1, 1'b1, 15'd3, 64'h140, 1'b1, 1'b0, 1'b0, 1'b0);
         chk1($sformatf("starve%0d_rdy", k), ig_ready, 1'b0);
         tick();
         chk32($sformatf("starve%0d_perf", k), perf, 32'(k + 1));
         chk1($sformatf("starve%0d_mv", k), mv, 1'b0);
      end
      for (int k = 0; k < 4; k++) begin
         drive(1'b0, 1'b0, 1'b1, 1'b1, 15'd3, 64'h140, 1'b1, 1'b0, 1'b1, 1'b0);
         chk1($sformatf("pop%0d_rdy", k), ig_ready, 1'b0);
         tick();
         chk32($sformatf("pop%0d_perf", k), perf, 32'(k + 4));
      end
      drive(1'b0, 1'b0, 1'b1, 1'b1, 15'd3, 64'h140, 1'b1, 1'b0, 1'b0, 1'b0);
      chk1("refill_rdy", ig_ready, 1'b1);
      tick();
      chk1("refill_mv", mv, 1'b1);
      chkpd("refill_pd", {15'd3, 64'h140});
      chk32("refill_perf", perf, 32'd7);
      chk32("refill_cdt", 32'(dut.cdt_avail_q), 32'd0);

      // Port backpressure: held request stays stable, next one waits
      do_reset();
      drive(1'b0, 1'b0, 1'b1, 1'b1, 15'd1, 64'hB0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk1("bp_first_rdy", ig_ready, 1'b1);
      tick();
      for (int k = 0; k < 5; k++) begin
         drive(1'b0, 1'b0, 1'b1, 1'b1, 15'd1, 64'hB1, 1'b0, 1'b0, 1'b0, 1'b0);
         chk1($sformatf("bp%0d_rdy", k), ig_ready, 1'b0);
         tick();
         chk1($sformatf("bp%0d_mv", k), mv, 1'b1);
         chkpd($sformatf("bp%0d_pd", k), {15'd1, 64'hB0});
         chk32($sformatf("bp%0d_perf", k), perf, 32'(k + 1));
      end
      // op_load on a stall cycle: clear wins over increment
      drive(1'b0, 1'b1, 1'b1, 1'b1, 15'd1, 64'hB1, 1'b0, 1'b0, 1'b0, 1'b0);
      chk1("bp_opl_rdy", ig_ready, 1'b0);
      tick();
      chk32("bp_opl_perf", perf, 32'd0);
      chk1("bp_opl_mv", mv, 1'b1);
      for (int k = 0; k < 4; k++) begin
         drive(1'b0, 1'b0, 1'b1, 1'b1, 15'd1, 64'hB1 + 64'(k), 1'b1, 1'b0, 1'b0, 1'b0);
         chk1($sformatf("flow%0d_rdy", k), ig_ready, 1'b1);
         tick();
         chk1($sformatf("flow%0d_mv", k), mv, 1'b1);
         chkpd($sformatf("flow%0d_pd", k), {15'd1, 64'hB1 + 64'(k)});
      end
      chk32("flow_perf", perf, 32'd0);

      // Accept with both pops in the same cycle
      do_reset();
      drive(1'b0, 1'b0, 1'b1, 1'b1, 15'd155, 64'hC0, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      chk32("dual_cdt100", 32'(dut.cdt_avail_q), 32'd100);
      drive(1'b0, 1'b0, 1'b1, 1'b1, 15'd3, 64'hC1, 1'b1, 1'b0, 1'b1, 1'b1);
      chk1("dual_rdy", ig_ready, 1'b1);
      tick();
      chk32("dual_cdt98", 32'(dut.cdt_avail_q), 32'd98);

      // Credit overflow, then op_load clears error and perf
      do_reset();
      drive(1'b0, 1'b0, 1'b1, 1'b0, 15'd0, 64'h0, 1'b1, 1'b1, 1'b1, 1'b0);
      tick();
      chk32("ovf_cdt", 32'(dut.cdt_avail_q), 32'd256);
      chk1("ovf_err", err, 1'b1);
      chk1("ovf_busy", busy, 1'b0);
      drive(1'b0, 1'b0, 1'b1, 1'b1, 15'h7FFF, 64'hD0, 1'b1, 1'b1, 1'b0, 1'b0);
      chk1("big_rdy", ig_ready, 1'b0);
      tick();
      chk32("big_perf", perf, 32'd1);
      chk1("big_mv", mv, 1'b0);
      drive(1'b0, 1'b1, 1'b1, 1'b0, 15'd0, 64'h0, 1'b1, 1'b1, 1'b0, 1'b0);
      tick();
      chk1("clr_err", err, 1'b0);
      chk32("clr_perf", perf, 32'd0);

      // Alternating routing, in order, each request exactly once
      do_reset();
      for (int k = 0; k < 8; k++) begin
         drive(1'b0, 1'b0, (k % 2) == 0, 1'b1, 15'd2, 64'hE0 + 64'(k), 1'b1, 1'b1, 1'b0, 1'b0);
         chk1($sformatf("alt%0d_rdy", k), ig_ready, 1'b1);
         tick();
         chk1($sformatf("alt%0d_mv", k), mv, (k % 2) == 0);
         chk1($sformatf("alt%0d_cv", k), cv, (k % 2) != 0);
         chkpd($sformatf("alt%0d_pd", k), {15'd2, 64'hE0 + 64'(k)});
      end
      drive(1'b0, 1'b0, 1'b1, 1'b0, 15'd2, 64'h0, 1'b1, 1'b1, 1'b0, 1'b0);
      tick();
      chk1("alt_end_mv", mv, 1'b0);
      chk1("alt_end_cv", cv, 1'b0);
      chk32("alt_end_cdt", 32'(dut.cdt_avail_q), 32'd232);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
